// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the fetch/data memory arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_valid;
  logic [15:0]           if_rdata;
  logic                  if_err;

  logic                  dm_req;
  logic                  dm_wr;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [15:0]           dm_wdata;
  logic                  dm_gnt;
  logic                  dm_valid;
  logic [15:0]           dm_rdata;
  logic                  dm_err;

  logic                  mem_en;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wdata;
  logic [15:0]           mem_rdata;

  modport master (
    output if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_valid, if_rdata, if_err,
    input  dm_gnt, dm_valid, dm_rdata, dm_err,
    input  mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    input  if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_valid, if_rdata, if_err,
    output dm_gnt, dm_valid, dm_rdata, dm_err,
    output mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one 16-bit single-port memory between the fetch port and the data port,
// one fixed-latency transaction at a time, data port first with a fetch starvation guard.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [STV_W-1:0]      r_starve;
  logic                  r_isDm;
  logic                  r_wr;
  logic                  r_memEn;
  logic                  r_memWr;
  logic [ADDR_WIDTH-1:0] r_memAddr;
  logic [15:0]           r_memWdata;
  logic                  r_ifValid;
  logic                  r_ifErr;
  logic [15:0]           r_ifRdata;
  logic                  r_dmValid;
  logic                  r_dmErr;
  logic [15:0]           r_dmRdata;

  logic                  w_pickIf;
  logic                  w_ifGnt;
  logic                  w_dmGnt;
  logic                  w_selWr;
  logic                  w_selMis;
  logic [ADDR_WIDTH-1:0] w_selAddr;
  logic [15:0]           w_selWdata;

  // Grants are combinational so the requester sees acceptance in the cycle its inputs are latched.
  assign w_pickIf   = bus.if_req && (!bus.dm_req || (r_starve == STV_MAX));
  assign w_ifGnt    = (r_state == S_IDLE) && w_pickIf;
  assign w_dmGnt    = (r_state == S_IDLE) && bus.dm_req && !w_pickIf;
  assign w_selAddr  = w_ifGnt ? bus.if_addr : bus.dm_addr;
  assign w_selWr    = w_dmGnt && bus.dm_wr;
  assign w_selWdata = w_dmGnt ? bus.dm_wdata : 16'h0000;
  assign w_selMis   = w_selAddr[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_starve   <= '0;
      r_isDm     <= 1'b0;
      r_wr       <= 1'b0;
      r_memEn    <= 1'b0;
      r_memWr    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_ifValid  <= 1'b0;
      r_ifErr    <= 1'b0;
      r_ifRdata  <= '0;
      r_dmValid  <= 1'b0;
      r_dmErr    <= 1'b0;
      r_dmRdata  <= '0;
    end else begin
      r_ifValid <= 1'b0;
      r_ifErr   <= 1'b0;
      r_dmValid <= 1'b0;
      r_dmErr   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_ifGnt || w_dmGnt) begin
            r_isDm     <= w_dmGnt;
            r_wr       <= w_selWr;
            r_memAddr  <= {w_selAddr[ADDR_WIDTH-1:1], 1'b0};
            r_memWdata <= w_selWdata;
            if (w_ifGnt) begin
              r_starve <= '0;
            end else if (bus.if_req && (r_starve != STV_MAX)) begin
              r_starve <= r_starve + 1'b1;
            end
            // Misaligned requests never touch memory and answer on the next cycle.
            if (w_selMis) begin
              r_state   <= S_RESP;
              r_ifValid <= w_ifGnt;
              r_ifErr   <= w_ifGnt;
              r_dmValid <= w_dmGnt;
              r_dmErr   <= w_dmGnt;
              if (w_ifGnt) begin
                r_ifRdata <= '0;
              end else begin
                r_dmRdata <= '0;
              end
            end else begin
              r_state <= S_ACCESS;
              r_cnt   <= CNT_INIT;
              r_memEn <= 1'b1;
              r_memWr <= w_selWr && (CNT_INIT == '0);
            end
          end
        end
        S_ACCESS: begin
          if (r_cnt == '0) begin
            r_state <= S_RESP;
            r_memEn <= 1'b0;
            r_memWr <= 1'b0;
            if (r_isDm) begin
              r_dmValid <= 1'b1;
              r_dmRdata <= r_wr ? 16'h0000 : bus.mem_rdata;
            end else begin
              r_ifValid <= 1'b1;
              r_ifRdata <= bus.mem_rdata;
            end
          end else begin
            r_cnt   <= r_cnt - 1'b1;
            r_memWr <= r_wr && (r_cnt == CNT_W'(1));
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.if_gnt    = w_ifGnt;
  assign bus.if_valid  = r_ifValid;
  assign bus.if_err    = r_ifErr;
  assign bus.if_rdata  = r_ifRdata;
  assign bus.dm_gnt    = w_dmGnt;
  assign bus.dm_valid  = r_dmValid;
  assign bus.dm_err    = r_dmErr;
  assign bus.dm_rdata  = r_dmRdata;
  assign bus.mem_en    = r_memEn;
  assign bus.mem_wr    = r_memWr;
  assign bus.mem_addr  = r_memAddr;
  assign bus.mem_wdata = r_memWdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a LATENCY=2 instance for directed scenarios and a LATENCY=1
// instance for a random sweep, both checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int AW   = 16;
  localparam int SMAX = 3;

  typedef struct packed {
    logic        ifGnt;
    logic        ifValid;
    logic        ifErr;
    logic        dmGnt;
    logic        dmValid;
    logic        dmErr;
    logic        memEn;
    logic        memWr;
    logic [15:0] ifRdata;
    logic [15:0] dmRdata;
    logic [15:0] memAddr;
    logic [15:0] memWdata;
  } obs_t;

  typedef struct {
    bit          busy;
    int          age;
    bit          isDm;
    bit          wr;
    bit          mis;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          starve;
    logic [15:0] ifRdata;
    logic [15:0] dmRdata;
  } mdl_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW)) bus2 ();
  mem_port_arbiter_if #(.ADDR_WIDTH(AW)) bus1 ();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .LATENCY(2), .STARVE_MAX(SMAX)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
  );
  mem_port_arbiter #(.ADDR_WIDTH(AW), .LATENCY(1), .STARVE_MAX(SMAX)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
  );

  logic [15:0] dutMem [0:1][0:32767];
  logic [15:0] refMem [0:1][0:32767];
  mdl_t        mdl [0:1];

  int checkCount = 0;
  int passCount  = 0;
  int memWrCnt2  = 0;
  int memEnCnt2  = 0;
  int validCnt [0:1];
  int gntCnt [0:1];
  bit logGrants  = 1'b0;
  bit grantLog [$];

  assign bus2.mem_rdata = dutMem[0][bus2.mem_addr[15:1]];
  assign bus1.mem_rdata = dutMem[1][bus1.mem_addr[15:1]];

  always @(posedge clk) begin
    if (bus2.mem_en && bus2.mem_wr) dutMem[0][bus2.mem_addr[15:1]] = bus2.mem_wdata;
    if (bus1.mem_en && bus1.mem_wr) dutMem[1][bus1.mem_addr[15:1]] = bus1.mem_wdata;
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic obs_t readObs(input int sel);
    obs_t o;
    if (sel == 0) begin
      o = {bus2.if_gnt, bus2.if_valid, bus2.if_err, bus2.dm_gnt, bus2.dm_valid, bus2.dm_err,
           bus2.mem_en, bus2.mem_wr, bus2.if_rdata, bus2.dm_rdata, bus2.mem_addr, bus2.mem_wdata};
    end else begin
      o = {bus1.if_gnt, bus1.if_valid, bus1.if_err, bus1.dm_gnt, bus1.dm_valid, bus1.dm_err,
           bus1.mem_en, bus1.mem_wr, bus1.if_rdata, bus1.dm_rdata, bus1.mem_addr, bus1.mem_wdata};
    end
    return o;
  endfunction

  // The model tracks each transaction by its age in cycles since grant and predicts
  // outputs for the current cycle, then advances across the coming rising edge.
  task automatic stepModel(input int sel);
    obs_t        a;
    obs_t        e;
    mdl_t        s;
    mdl_t        n;
    int          lat;
    int          respAge;
    bit          pickIf;
    bit          pickDm;
    logic        ifReq;
    logic        dmReq;
    logic        dmWr;
    logic [15:0] ifAddr;
    logic [15:0] dmAddr;
    logic [15:0] dmWdata;
    string       p;
    p   = (sel == 0) ? "L2" : "L1";
    lat = (sel == 0) ? 2 : 1;
    a   = readObs(sel);
    if (sel == 0) begin
      ifReq = bus2.if_req; ifAddr = bus2.if_addr;
      dmReq = bus2.dm_req; dmWr = bus2.dm_wr; dmAddr = bus2.dm_addr; dmWdata = bus2.dm_wdata;
    end else begin
      ifReq = bus1.if_req; ifAddr = bus1.if_addr;
      dmReq = bus1.dm_req; dmWr = bus1.dm_wr; dmAddr = bus1.dm_addr; dmWdata = bus1.dm_wdata;
    end
    e = '0;
    s = mdl[sel];
    n = s;
    if (!rst_n) begin
      n = '{default: '0};
    end else begin
      e.ifRdata = s.ifRdata;
      e.dmRdata = s.dmRdata;
      if (s.busy) begin
        respAge = s.mis ? 1 : lat + 1;
        if (!s.mis && s.age <= lat) begin
          e.memEn    = 1'b1;
          e.memAddr  = {s.addr[15:1], 1'b0};
          e.memWdata = s.wdata;
          e.memWr    = s.wr && (s.age == lat);
        end
        if (e.memWr) refMem[sel][s.addr[15:1]] = s.wdata;
        if (s.age == respAge) begin
          if (s.isDm) begin e.dmValid = 1'b1; e.dmErr = s.mis; end
          else begin e.ifValid = 1'b1; e.ifErr = s.mis; end
          n.busy = 1'b0;
        end else begin
          n.age = s.age + 1;
          if (n.age == respAge) begin
            if (s.isDm) n.dmRdata = s.wr ? 16'h0000 : refMem[sel][s.addr[15:1]];
            else n.ifRdata = refMem[sel][s.addr[15:1]];
          end
        end
      end else begin
        pickIf  = ifReq && (!dmReq || s.starve == SMAX);
        pickDm  = dmReq && !pickIf;
        e.ifGnt = pickIf;
        e.dmGnt = pickDm;
        if (pickIf || pickDm) begin
          n.busy  = 1'b1;
          n.age   = 1;
          n.isDm  = pickDm;
          n.wr    = pickDm && dmWr;
          n.addr  = pickDm ? dmAddr : ifAddr;
          n.wdata = dmWdata;
          n.mis   = n.addr[0];
          if (pickIf) n.starve = 0;
          else if (ifReq) n.starve = (s.starve < SMAX) ? s.starve + 1 : SMAX;
          if (n.mis && pickDm) n.dmRdata = 16'h0000;
          if (n.mis && pickIf) n.ifRdata = 16'h0000;
        end
      end
    end
    mdl[sel] = n;
    checkOutput({p, ".if_gnt"}, 16'(a.ifGnt), 16'(e.ifGnt));
    checkOutput({p, ".dm_gnt"}, 16'(a.dmGnt), 16'(e.dmGnt));
    checkOutput({p, ".if_valid"}, 16'(a.ifValid), 16'(e.ifValid));
    checkOutput({p, ".dm_valid"}, 16'(a.dmValid), 16'(e.dmValid));
    checkOutput({p, ".if_err"}, 16'(a.ifErr), 16'(e.ifErr));
    checkOutput({p, ".dm_err"}, 16'(a.dmErr), 16'(e.dmErr));
    checkOutput({p, ".mem_en"}, 16'(a.memEn), 16'(e.memEn));
    checkOutput({p, ".mem_wr"}, 16'(a.memWr), 16'(e.memWr));
    checkOutput({p, ".if_rdata"}, a.ifRdata, e.ifRdata);
    checkOutput({p, ".dm_rdata"}, a.dmRdata, e.dmRdata);
    if (e.memEn || !rst_n) checkOutput({p, ".mem_addr"}, a.memAddr, e.memAddr);
    if (e.memWr) checkOutput({p, ".mem_wdata"}, a.memWdata, e.memWdata);
  endtask

  always @(negedge clk) begin
    stepModel(0);
    stepModel(1);
  end

  always @(negedge clk) begin
    if (bus2.mem_wr) memWrCnt2++;
    if (bus2.mem_en) memEnCnt2++;
    validCnt[0] += int'(bus2.if_valid) + int'(bus2.dm_valid);
    validCnt[1] += int'(bus1.if_valid) + int'(bus1.dm_valid);
    gntCnt[1]   += int'(bus1.if_gnt) + int'(bus1.dm_gnt);
    if (logGrants && (bus2.if_gnt || bus2.dm_gnt)) grantLog.push_back(bus2.dm_gnt);
  end

  task automatic setReq(input int sel, input bit isDm, input bit wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input bit on);
    if (sel == 0) begin
      if (isDm) begin bus2.dm_req = on; bus2.dm_wr = wr; bus2.dm_addr = addr; bus2.dm_wdata = wdata; end
      else begin bus2.if_req = on; bus2.if_addr = addr; end
    end else begin
      if (isDm) begin bus1.dm_req = on; bus1.dm_wr = wr; bus1.dm_addr = addr; bus1.dm_wdata = wdata; end
      else begin bus1.if_req = on; bus1.if_addr = addr; end
    end
  endtask

  function automatic bit gntOf(input int sel, input bit isDm);
    if (sel == 0) return isDm ? bus2.dm_gnt : bus2.if_gnt;
    return isDm ? bus1.dm_gnt : bus1.if_gnt;
  endfunction

  function automatic bit validOf(input int sel, input bit isDm);
    if (sel == 0) return isDm ? bus2.dm_valid : bus2.if_valid;
    return isDm ? bus1.dm_valid : bus1.if_valid;
  endfunction

  // Raises a request, waits for its grant, then drops it just after the latching edge.
  task automatic applyStimulus(input int sel, input bit isDm, input bit wr, input logic [15:0] addr,
                               input logic [15:0] wdata);
    bit got;
    @(posedge clk); #1;
    setReq(sel, isDm, wr, addr, wdata, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = gntOf(sel, isDm);
    end
    checkOutput("gnt_seen", 16'(got), 16'h0001);
    @(posedge clk); #1;
    setReq(sel, isDm, 1'b0, 16'h0000, 16'h0000, 1'b0);
  endtask

  task automatic waitValid(input int sel, input bit isDm, output int cycles);
    bit got;
    got = 1'b0;
    cycles = 0;
    while (!got && cycles < 20) begin
      @(negedge clk);
      cycles++;
      got = validOf(sel, isDm);
    end
    checkOutput("valid_seen", 16'(got), 16'h0001);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, passed %0d of %0d", passCount, checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          c;
    bit          expOrder [8];
    bit          isDm;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          memDiff;

    for (int i = 0; i < 32768; i++) begin
      dutMem[0][i] = 16'(i * 7 + 3);
      dutMem[1][i] = 16'(i * 7 + 3);
      refMem[0][i] = 16'(i * 7 + 3);
      refMem[1][i] = 16'(i * 7 + 3);
    end
    dutMem[0][16'h0020] = 16'hBEEF;
    refMem[0][16'h0020] = 16'hBEEF;
    for (int s = 0; s < 2; s++) begin
      mdl[s] = '{default: '0};
      validCnt[s] = 0;
      gntCnt[s] = 0;
      setReq(s, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      setReq(s, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    end

    #3;
    checkOutput("reset.mem_en", 16'(bus2.mem_en), 16'h0000);
    checkOutput("reset.if_rdata", bus2.if_rdata, 16'h0000);
    checkOutput("reset.dm_valid", 16'(bus2.dm_valid), 16'h0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] single fetch from 0x0040");
    applyStimulus(0, 1'b0, 1'b0, 16'h0040, 16'h0000);
    @(negedge clk);
    checkOutput("fetch.t1.mem_en", 16'(bus2.mem_en), 16'h0001);
    checkOutput("fetch.t1.mem_addr", bus2.mem_addr, 16'h0040);
    @(negedge clk);
    checkOutput("fetch.t2.mem_en", 16'(bus2.mem_en), 16'h0001);
    @(negedge clk);
    checkOutput("fetch.t3.mem_en", 16'(bus2.mem_en), 16'h0000);
    checkOutput("fetch.t3.if_valid", 16'(bus2.if_valid), 16'h0001);
    checkOutput("fetch.t3.if_rdata", bus2.if_rdata, 16'hBEEF);
    checkOutput("fetch.t3.if_err", 16'(bus2.if_err), 16'h0000);

    $display("[TB] data write then read at 0x0010");
    memWrCnt2 = 0;
    applyStimulus(0, 1'b1, 1'b1, 16'h0010, 16'h1234);
    waitValid(0, 1'b1, c);
    checkOutput("write.latency", 16'(c), 16'h0003);
    checkOutput("write.dm_rdata", bus2.dm_rdata, 16'h0000);
    checkOutput("write.dm_err", 16'(bus2.dm_err), 16'h0000);
    checkOutput("write.mem_wr_cycles", 16'(memWrCnt2), 16'h0001);
    checkOutput("write.mem_word", dutMem[0][8], 16'h1234);
    applyStimulus(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    waitValid(0, 1'b1, c);
    checkOutput("read.dm_rdata", bus2.dm_rdata, 16'h1234);

    $display("[TB] both ports requesting continuously");
    expOrder = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    grantLog.delete();
    logGrants = 1'b1;
    @(posedge clk); #1;
    setReq(0, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b1);
    setReq(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1);
    for (int i = 0; i < 100 && grantLog.size() < 8; i++) @(negedge clk);
    @(posedge clk); #1;
    logGrants = 1'b0;
    setReq(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    setReq(0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    checkOutput("starve.grant_count", 16'(grantLog.size()), 16'h0008);
    for (int i = 0; i < 8 && i < grantLog.size(); i++) begin
      checkOutput($sformatf("starve.grant%0d_is_dm", i), 16'(grantLog[i]), 16'(expOrder[i]));
    end
    repeat (5) @(posedge clk);

    $display("[TB] misaligned data write to 0x0011");
    memEnCnt2 = 0;
    applyStimulus(0, 1'b1, 1'b1, 16'h0011, 16'hAAAA);
    @(negedge clk);
    checkOutput("mis.dm_valid", 16'(bus2.dm_valid), 16'h0001);
    checkOutput("mis.dm_err", 16'(bus2.dm_err), 16'h0001);
    checkOutput("mis.dm_rdata", bus2.dm_rdata, 16'h0000);
    repeat (2) @(negedge clk);
    checkOutput("mis.mem_en_cycles", 16'(memEnCnt2), 16'h0000);
    checkOutput("mis.mem_word", dutMem[0][8], 16'h1234);

    $display("[TB] reset during final write access cycle");
    applyStimulus(0, 1'b1, 1'b1, 16'h0020, 16'h5555);
    @(posedge clk); #1;
    checkOutput("rst.pre.mem_wr", 16'(bus2.mem_wr), 16'h0001);
    rst_n = 1'b0;
    #1;
    checkOutput("rst.mem_wr", 16'(bus2.mem_wr), 16'h0000);
    checkOutput("rst.mem_en", 16'(bus2.mem_en), 16'h0000);
    checkOutput("rst.if_rdata", bus2.if_rdata, 16'h0000);
    checkOutput("rst.dm_valid", 16'(bus2.dm_valid), 16'h0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    validCnt[0] = 0;
    repeat (6) @(negedge clk);
    checkOutput("rst.no_valid_after", 16'(validCnt[0]), 16'h0000);
    checkOutput("rst.mem_word", dutMem[0][16'h0010], 16'h0073);
    applyStimulus(0, 1'b1, 1'b0, 16'h0040, 16'h0000);
    waitValid(0, 1'b1, c);
    checkOutput("rst.after.latency", 16'(c), 16'h0003);
    checkOutput("rst.after.dm_rdata", bus2.dm_rdata, 16'hBEEF);

    $display("[TB] LATENCY=1 sweep of 50 mixed requests");
    gntCnt[1] = 0;
    validCnt[1] = 0;
    for (int k = 0; k < 50; k++) begin
      isDm  = 1'($urandom_range(0, 1));
      wr    = isDm && ($urandom_range(0, 2) == 0);
      addr  = {11'h000, 4'($urandom_range(0, 15)), 1'b0};
      if ($urandom_range(0, 7) == 0) addr[0] = 1'b1;
      wdata = 16'($urandom);
      applyStimulus(1, isDm, wr, addr, wdata);
      waitValid(1, isDm, c);
      checkOutput($sformatf("sweep%0d.latency", k), 16'(c), addr[0] ? 16'h0001 : 16'h0002);
    end
    @(negedge clk);
    checkOutput("sweep.gnt_count", 16'(gntCnt[1]), 16'd50);
    checkOutput("sweep.valid_count", 16'(validCnt[1]), 16'd50);
    memDiff = 0;
    for (int i = 0; i < 64; i++) if (dutMem[1][i] !== refMem[1][i]) memDiff++;
    checkOutput("sweep.mem_words_differing", 16'(memDiff), 16'h0000);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
